// File: rtl/da_fir_sequencer.sv
// da_fir_sequencer
//   Control sequencer for a distributed-arithmetic FIR datapath. It accepts one
//   sample per ready/valid handshake and strobes the delay-line shift and the
//   bit-serial register load. It then runs DATA_W LSB-first accumulate cycles and
//   presents the result downstream. Results are held back until the delay line
//   holds TAPS real samples.
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   soft_clr             synchronous flush (dominates everything)
//   in_valid/in_data/in_ready   upstream sample handshake
//   sample_q             captured sample presented to the delay-line input
//   dl_shift, dl_clr     delay-line shift / clear strobes
//   sr_load              parallel-load strobe for the bit-serial registers
//   bit_en, bit_idx      bit-serial enable and current bit index
//   acc_clr, acc_sub     accumulator load-first-term / subtract-sign-term
//   out_valid/out_ready  downstream result handshake
//   primed               delay line holds TAPS samples
module da_fir_sequencer #(
  parameter int DATA_W = 16,
  parameter int TAPS   = 64,
  parameter int CNT_W  = 7
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      soft_clr,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      in_ready,
  output logic [DATA_W-1:0]         sample_q,
  output logic                      dl_shift,
  output logic                      dl_clr,
  output logic                      sr_load,
  output logic                      bit_en,
  output logic [$clog2(DATA_W)-1:0] bit_idx,
  output logic                      acc_clr,
  output logic                      acc_sub,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      primed
);

  localparam int IDX_W = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, SHIFT, LOAD, ACCUM, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] fill_cnt;
  logic             run_q;      // low only until the first edge after reset release
  logic             dl_clr_q;
  logic             is_primed;
  logic             last_bit;
  logic             accept;

  assign is_primed = (fill_cnt == CNT_W'(TAPS));
  assign last_bit  = (bit_idx == IDX_W'(DATA_W - 1));
  assign accept    = (state == IDLE) && run_q && in_valid && !soft_clr;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (soft_clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nxt = SHIFT;
        SHIFT:   state_nxt = LOAD;
        LOAD:    state_nxt = ACCUM;
        ACCUM:   if (last_bit) state_nxt = DONE;
        DONE:    if (!is_primed || out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Moore output decode: everything comes from registered state
  always_comb begin
    in_ready  = (state == IDLE) && run_q;
    dl_shift  = (state == SHIFT);
    sr_load   = (state == LOAD);
    bit_en    = (state == ACCUM);
    acc_clr   = (state == ACCUM) && (bit_idx == '0);
    acc_sub   = (state == ACCUM) && last_bit;
    out_valid = (state == DONE) && is_primed;
    dl_clr    = dl_clr_q;
    primed    = is_primed;
  end

  // Datapath registers: fill counter, bit index, captured sample
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run_q    <= 1'b0;
      dl_clr_q <= 1'b0;
      fill_cnt <= '0;
      bit_idx  <= '0;
      sample_q <= '0;
    end else begin
      run_q    <= 1'b1;
      dl_clr_q <= soft_clr;
      if (soft_clr) begin
        fill_cnt <= '0;
        bit_idx  <= '0;
        sample_q <= '0;
      end else begin
        if (accept) begin
          sample_q <= in_data;
          if (!is_primed) fill_cnt <= fill_cnt + CNT_W'(1);
        end
        if (state == LOAD) begin
          bit_idx <= '0;
        end else if (state == ACCUM) begin
          // Return to 0 after the sign bit so idle cycles see index 0.
          if (last_bit) bit_idx <= '0;
          else          bit_idx <= bit_idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_da_fir_sequencer.sv
// Testbench for da_fir_sequencer. A transaction-level reference model tracks
// how many cycles have elapsed since each accept and derives every output from
// the documented latency schedule.
module tb_da_fir_sequencer;

  localparam int DW   = 16;
  localparam int TAPS = 64;
  localparam int IW   = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          soft_clr = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b1;
  logic          in_ready, dl_shift, dl_clr, sr_load, bit_en;
  logic          acc_clr, acc_sub, out_valid, primed;
  logic [DW-1:0] sample_q;
  logic [IW-1:0] bit_idx;

  always #5 clk = ~clk;

  da_fir_sequencer #(.DATA_W(DW), .TAPS(TAPS), .CNT_W(7)) dut (
    .clk(clk), .resetn(resetn), .soft_clr(soft_clr),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .sample_q(sample_q), .dl_shift(dl_shift), .dl_clr(dl_clr),
    .sr_load(sr_load), .bit_en(bit_en), .bit_idx(bit_idx),
    .acc_clr(acc_clr), .acc_sub(acc_sub), .out_valid(out_valid),
    .out_ready(out_ready), .primed(primed)
  );

  // Reference model: m_since counts cycles since the accept (1=shift,
  // 2=load, 3..18=accumulate, 19=result).
  bit          m_alive, m_busy, m_dlclr, m_acc;
  int          m_since, m_fill;
  logic [DW-1:0] m_sample;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic model_reset();
    m_alive = 0; m_busy = 0; m_dlclr = 0; m_acc = 0;
    m_since = 0; m_fill = 0; m_sample = '0;
  endtask

  task automatic model_step();
    m_acc = 0;
    if (!resetn) begin
      model_reset();
      return;
    end
    m_dlclr = soft_clr;
    if (soft_clr) begin
      m_busy = 0; m_fill = 0; m_sample = '0;
    end else if (!m_busy) begin
      if (m_alive && in_valid) begin
        m_acc = 1; m_busy = 1; m_since = 1; m_sample = in_data;
        m_fill = (m_fill + 1 > TAPS) ? TAPS : m_fill + 1;
      end
    end else if (m_since < DW + 3) begin
      m_since++;
    end else if (m_fill != TAPS || out_ready) begin
      m_busy = 0;
    end
    m_alive = 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    bit en;
    en = m_busy && m_since >= 3 && m_since <= DW + 2;
    chk("in_ready",  32'(in_ready),  32'(m_alive && !m_busy));
    chk("dl_shift",  32'(dl_shift),  32'(m_busy && m_since == 1));
    chk("sr_load",   32'(sr_load),   32'(m_busy && m_since == 2));
    chk("bit_en",    32'(bit_en),    32'(en));
    chk("bit_idx",   32'(bit_idx),   en ? 32'(m_since - 3) : 32'd0);
    chk("acc_clr",   32'(acc_clr),   32'(m_busy && m_since == 3));
    chk("acc_sub",   32'(acc_sub),   32'(m_busy && m_since == DW + 2));
    chk("out_valid", 32'(out_valid), 32'(m_busy && m_since == DW + 3 && m_fill == TAPS));
    chk("primed",    32'(primed),    32'(m_fill == TAPS));
    chk("dl_clr",    32'(dl_clr),    32'(m_dlclr));
    chk("sample_q",  32'(sample_q),  32'(m_sample));
  endtask

  // Check at the negedge, step across one posedge, return to the negedge.
  task automatic cycle();
    check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (m_acc) in_data = DW'($urandom);
  endtask

  initial begin
    model_reset();
    #1 resetn = 1'b0;
    @(negedge clk);
    repeat (3) cycle();
    resetn = 1'b1;
    repeat (10) cycle();

    // Single sample, unprimed
    in_data = 16'h1234; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("sample_1234", 32'(sample_q), 32'h1234);
    repeat (22) cycle();

    // Fill the delay line with in_valid held high
    in_valid = 1'b1;
    repeat (63 * 20 + 2) cycle();
    in_valid = 1'b0;
    repeat (25) cycle();
    chk("primed_after_fill", 32'(primed), 32'd1);

    // Back-pressure on a primed result
    out_ready = 1'b0; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (24) cycle();
    out_ready = 1'b1;
    repeat (3) cycle();

    // Randomized traffic with occasional flushes
    repeat (400) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      soft_clr  = ($urandom_range(0, 99) == 0);
      cycle();
    end
    soft_clr = 1'b0; out_ready = 1'b1;

    // Refill to primed
    in_valid = 1'b1;
    repeat (64 * 20 + 5) cycle();
    in_valid = 1'b0;
    repeat (22) cycle();

    // Flush at bit index 7 with a coincident in_valid
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    for (int k = 0; k < 40 && !(m_busy && m_since == 10); k++) cycle();
    chk("bit_idx_at_clr", 32'(bit_idx), 32'd7);
    soft_clr = 1'b1; in_valid = 1'b1;
    cycle();
    soft_clr = 1'b0; in_valid = 1'b0;
    chk("dl_clr_pulse", 32'(dl_clr), 32'd1);
    chk("primed_after_clr", 32'(primed), 32'd0);
    in_valid = 1'b1;
    repeat (63 * 20) cycle();
    in_valid = 1'b0;
    repeat (25) cycle();
    chk("primed_after_63", 32'(primed), 32'd0);

    // 64th sample, hold result, then reset asynchronously mid-DONE
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (25) cycle();
    chk("out_valid_held", 32'(out_valid), 32'd1);
    resetn = 1'b0;
    #1;
    model_reset();
    chk("out_valid_async_drop", 32'(out_valid), 32'd0);
    check_all();
    @(negedge clk);
    repeat (2) cycle();
    resetn = 1'b1; out_ready = 1'b1;
    repeat (5) cycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/da_fir_sequencer.md
Name: da_fir_sequencer

Overview:
- Control FSM for the distributed-arithmetic FIR datapath: 64-tap sample delay line, bank of bit-serial parallel-load shift registers, and LUT shift-accumulator.
- Accepts one sample per ready/valid handshake and strobes the delay-line shift and the shift-register load.
- Runs DATA_W bit-serial accumulate cycles with accumulator clear/subtract controls, then presents a result-valid handshake downstream.
- Suppresses results until the delay line holds TAPS real samples.

Parameters:
- DATA_W, 16: sample width; equals the number of bit-serial accumulate cycles per output.
- TAPS, 64: delay-line depth; samples required before outputs are released.
- CNT_W, 7: fill-counter width; must satisfy 2^CNT_W > TAPS.

Ports:
- clk  in  1  single system clock; all state changes on posedge.
- resetn  in  1  asynchronous active-low reset.
- soft_clr  in  1  synchronous flush request.
- in_valid  in  1  upstream sample valid.
- in_data  in  DATA_W  upstream sample.
- in_ready  out  1  sequencer can accept a sample.
- sample_q  out  DATA_W  captured sample presented to the delay-line input.
- dl_shift  out  1  one-cycle delay-line shift strobe.
- dl_clr  out  1  one-cycle delay-line/shift-register clear strobe.
- sr_load  out  1  one-cycle parallel-load strobe to the bit-serial registers.
- bit_en  out  1  bit-serial shift and accumulate enable.
- bit_idx  out  $clog2(DATA_W)  current bit index, LSB first.
- acc_clr  out  1  accumulator loads the LUT term instead of adding (first bit).
- acc_sub  out  1  accumulator subtracts the LUT term (sign bit, last bit).
- out_valid  out  1  accumulator result ready.
- out_ready  in  1  downstream accepts the result.
- primed  out  1  fill_cnt == TAPS.

Behaviour:
- Async reset (resetn=0):
  - state=IDLE, fill_cnt=0, bit_idx=0, sample_q=0.
  - All strobes and out_valid = 0; in_ready=0 while resetn=0.
- All outputs are decoded from registers (Moore). There is no combinational path from any input to any output.
- States: IDLE, SHIFT, LOAD, ACCUM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1: sample_q<=in_data, fill_cnt<=min(fill_cnt+1, TAPS), go to SHIFT.
- SHIFT: dl_shift=1 for exactly one cycle, then go to LOAD.
- LOAD: sr_load=1 for exactly one cycle, bit_idx<=0, then go to ACCUM.
- ACCUM:
  - bit_en=1 for exactly DATA_W consecutive cycles; bit_idx counts 0..DATA_W-1.
  - acc_clr=1 only when bit_idx=0; acc_sub=1 only when bit_idx=DATA_W-1.
  - After bit_idx=DATA_W-1, go to DONE.
- DONE:
  - If primed: out_valid=1 and held until out_ready=1; on that cycle go to IDLE.
  - If not primed: out_valid stays 0; DONE lasts one cycle, then go to IDLE (result discarded).
- Latency: accept at edge 0; SHIFT cycle 1; LOAD cycle 2; ACCUM cycles 3..18; out_valid first high cycle 19 (DATA_W=16). Minimum sample period = DATA_W+4 cycles.
- Back-pressure: in_ready=0 in every state except IDLE. in_valid during SHIFT/LOAD/ACCUM/DONE is ignored and must be held by the source.
- fill_cnt saturates at TAPS and never wraps. The accept that brings it to TAPS yields the first released result.
- soft_clr:
  - Dominates every state and in_valid. Next edge: state=IDLE, fill_cnt=0, bit_idx=0, all strobes 0, out_valid 0.
  - dl_clr=1 for the one cycle following the soft_clr cycle.
  - A pending result is dropped. An in_valid coincident with soft_clr is not accepted.
- Reset or soft_clr mid-ACCUM aborts with no partial out_valid.
- sample_q holds its value until the next accept. It changes only on accept, soft_clr (to 0), or reset.

Test Plan:
- Reset release, in_valid=0 for 10 cycles -> in_ready=1 from cycle 1; all strobes 0; fill_cnt=0; primed=0.
- Single sample 0x1234, out_ready=1 -> dl_shift at cycle 1, sr_load at cycle 2, bit_en cycles 3..18 with acc_clr at 3 and acc_sub at 18; out_valid stays 0 (unprimed); back in IDLE at cycle 20.
- 64 back-to-back samples with in_valid held high -> exactly one accept per 20 cycles; samples 1..63 give no out_valid; sample 64 gives out_valid at cycle 19 after its accept; primed=1.
- Primed, out_ready=0 for 5 cycles then 1 -> out_valid held 6 cycles, in_ready=0 throughout, IDLE on the following cycle; next sample accepted correctly.
- soft_clr asserted at bit_idx=7 -> IDLE next cycle, dl_clr pulse of 1 cycle, no out_valid, fill_cnt=0, primed=0; 63 further samples give no output.
- resetn pulsed low mid-DONE with out_valid=1 -> out_valid drops immediately (asynchronously); all outputs return to their reset values.
